// File: rtl/rv_fifo.sv
// Elastic valid/ready FIFO with explicit occupancy count, almost-full watermark and sync flush.
// Define RV_FIFO_BYPASS_EN for fall-through on empty (combinational in->out path).
module rv_fifo #(
  parameter int DW     = 32,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = DEPTH-1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW-1:0]                in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] mem [DEPTH];
  logic          push, pop, stored;

  assign stored   = (count_q != '0);
  // in_ready looks only at registered occupancy, so out_ready never reaches it.
  assign in_ready = (count_q != FULL_CNT);

`ifdef RV_FIFO_BYPASS_EN
  logic bypass;
  assign bypass    = !stored && in_valid;
  assign out_valid = stored || in_valid;
  assign out_data  = stored ? mem[rd_ptr_q] : (in_valid ? in_data : '0);
  // A beat taken straight through while empty is never written.
  assign push      = in_valid && in_ready && !(bypass && out_ready);
`else
  assign out_valid = stored;
  assign out_data  = stored ? mem[rd_ptr_q] : '0;
  assign push      = in_valid && in_ready;
`endif
  assign pop = stored && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= in_data;
  end

  assign count       = count_q;
  assign almost_full = (count_q >= AF_CNT);
endmodule
